ccip_tx_rr_arbiter: RTL and testbench

- Shares one upstream CCI-P Tx request channel among NUM_PORTS sub-AFU requesters.
- Sits inside the CCI-P mux tree at each mux level, on the request path toward the upstream port.
- Per-port request FIFOs with almost-full backpressure to each sub-AFU; quantum-limited round-robin issue gated by upstream almost-full.
- Tags each issued request with its source port index so the response path can route the reply back.

---
 rtl/ccip_arb_pkg.sv | 18 +
 rtl/ccip_arb_fifo.sv | 71 +++++++
 rtl/ccip_tx_rr_arbiter.sv | 139 +++++++++++++
 tb/tb_ccip_tx_rr_arbiter.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccip_arb_pkg.sv
// Shared definitions for the CCI-P Tx round-robin arbiter: default sizing,
// arbiter state encoding and the port-index width helper.
package ccip_arb_pkg;

   localparam int DEF_FIFO_DEPTH = 8;
   localparam int DEF_AF_SLACK   = 4;
   localparam int DEF_QUANTUM    = 4;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_HOLD = 1'b1
   } arb_state_e;

   function automatic int port_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ccip_arb_fifo.sv
// Single-clock request FIFO with registered almost-full; a push into a full
// FIFO is accepted only when the same edge also pops.
module ccip_arb_fifo
   import ccip_arb_pkg::*;
#(
   parameter int PAYLOAD_W = 600,
   parameter int DEPTH     = DEF_FIFO_DEPTH,
   parameter int AF_SLACK  = DEF_AF_SLACK
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 push,
   input  logic [PAYLOAD_W-1:0] wdata,
   input  logic                 pop,
   output logic [PAYLOAD_W-1:0] rdata,
   output logic                 full,
   output logic                 empty,
   output logic                 almfull
);

   localparam int AW   = $clog2(DEPTH);
   localparam int CNTW = AW + 1;

   logic [PAYLOAD_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0]      count_q, count_d;
   logic                 almfull_q, almfull_d;
   logic                 push_ok, pop_ok;

   assign full    = (count_q == CNTW'(DEPTH));
   assign empty   = (count_q == '0);
   assign rdata   = mem_q[rd_ptr_q];
   assign almfull = almfull_q;

   always_comb begin
      pop_ok   = pop && !empty;
      push_ok  = push && (!full || pop_ok);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      // Threshold on the post-edge occupancy so the flag is never a cycle stale.
      almfull_d = (count_d >= CNTW'(DEPTH - AF_SLACK));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         almfull_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         almfull_q <= almfull_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/ccip_tx_rr_arbiter.sv
// CCI-P Tx request arbiter: per-port FIFOs feed a quantum-limited round-robin
// issue stage that tags every upstream beat with its source port.
module ccip_tx_rr_arbiter
   import ccip_arb_pkg::*;
#(
   parameter int NUM_PORTS  = 4,
   parameter int PAYLOAD_W  = 600,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int AF_SLACK   = DEF_AF_SLACK,
   parameter int QUANTUM    = DEF_QUANTUM
) (
   input  logic                                pClk,
   input  logic                                pReset_n,
   input  logic [NUM_PORTS-1:0]                dn_valid,
   input  logic [NUM_PORTS-1:0][PAYLOAD_W-1:0] dn_payload,
   output logic [NUM_PORTS-1:0]                dn_almfull,
   input  logic                                up_almfull,
   output logic                                up_valid,
   output logic [PAYLOAD_W-1:0]                up_payload,
   output logic [$clog2(NUM_PORTS)-1:0]        up_port,
   output logic [NUM_PORTS-1:0]                ovf_err
);

   localparam int PIW = port_idx_w(NUM_PORTS);
   localparam int CW  = $clog2(QUANTUM + 1);

   logic [NUM_PORTS-1:0] fifo_pop, fifo_full, fifo_empty, fifo_af;
   logic [PAYLOAD_W-1:0] fifo_rdata [NUM_PORTS];

   arb_state_e           state_q, state_d;
   logic [PIW-1:0]       grant_q, grant_d;
   logic [PIW-1:0]       rr_q, rr_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 up_valid_q, up_valid_d;
   logic [PAYLOAD_W-1:0] up_payload_q, up_payload_d;
   logic [PIW-1:0]       up_port_q, up_port_d;
   logic [NUM_PORTS-1:0] ovf_q, ovf_d;

   logic                 hold_ok, found, issue;
   logic [PIW-1:0]       base, pick, sel;

   function automatic logic [PIW-1:0] wrap_inc(input logic [PIW-1:0] p);
      return (int'(p) == NUM_PORTS - 1) ? '0 : p + 1'b1;
   endfunction

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_fifo
      ccip_arb_fifo #(
         .PAYLOAD_W (PAYLOAD_W),
         .DEPTH     (FIFO_DEPTH),
         .AF_SLACK  (AF_SLACK)
      ) u_fifo (
         .clk     (pClk),
         .rst_n   (pReset_n),
         .push    (dn_valid[i]),
         .wdata   (dn_payload[i]),
         .pop     (fifo_pop[i]),
         .rdata   (fifo_rdata[i]),
         .full    (fifo_full[i]),
         .empty   (fifo_empty[i]),
         .almfull (fifo_af[i])
      );
   end

   always_ff @(posedge pClk or negedge pReset_n) begin
      if (!pReset_n) begin
         state_q      <= ARB_IDLE;
         grant_q      <= '0;
         rr_q         <= '0;
         cnt_q        <= '0;
         up_valid_q   <= 1'b0;
         up_payload_q <= '0;
         up_port_q    <= '0;
         ovf_q        <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         rr_q         <= rr_d;
         cnt_q        <= cnt_d;
         up_valid_q   <= up_valid_d;
         up_payload_q <= up_payload_d;
         up_port_q    <= up_port_d;
         ovf_q        <= ovf_d;
      end
   end

   // Leaving HOLD re-arbitrates in the same cycle from granted+1, so no bubble.
   always_comb begin
      hold_ok = (state_q == ARB_HOLD) && !fifo_empty[grant_q] && (cnt_q < CW'(QUANTUM));
      base    = (state_q == ARB_HOLD) ? wrap_inc(grant_q) : rr_q;
      found   = 1'b0;
      pick    = base;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         if (!fifo_empty[PIW'((int'(base) + k) % NUM_PORTS)]) begin
            found = 1'b1;
            pick  = PIW'((int'(base) + k) % NUM_PORTS);
         end
      end

      state_d = state_q;
      grant_d = grant_q;
      rr_d    = rr_q;
      cnt_d   = cnt_q;
      issue   = 1'b0;
      sel     = grant_q;
      if (!up_almfull) begin
         if (hold_ok) begin
            issue = 1'b1;
            cnt_d = cnt_q + 1'b1;
         end else begin
            rr_d = base;
            if (found) begin
               issue   = 1'b1;
               sel     = pick;
               grant_d = pick;
               cnt_d   = CW'(1);
               state_d = ARB_HOLD;
            end else begin
               state_d = ARB_IDLE;
            end
         end
      end
   end

   always_comb begin
      fifo_pop = '0;
      if (issue) fifo_pop[sel] = 1'b1;
      up_valid_d   = issue;
      up_payload_d = issue ? fifo_rdata[sel] : up_payload_q;
      up_port_d    = issue ? sel : up_port_q;
      ovf_d        = ovf_q | (dn_valid & fifo_full & ~fifo_pop);
   end

   assign up_valid   = up_valid_q;
   assign up_payload = up_payload_q;
   assign up_port    = up_port_q;
   assign ovf_err    = ovf_q;
   assign dn_almfull = fifo_af;

endmodule

// File: tb/tb_ccip_tx_rr_arbiter.sv
// Self-checking bench for ccip_tx_rr_arbiter: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a queue-level model.
module tb_ccip_tx_rr_arbiter;

   localparam int NP = 4;
   localparam int PW = 32;
   localparam int D  = 8;
   localparam int S  = 4;
   localparam int Q  = 4;

   logic                   pClk = 1'b0;
   logic                   pReset_n;
   logic [NP-1:0]          dn_valid;
   logic [NP-1:0][PW-1:0]  dn_payload;
   logic [NP-1:0]          dn_almfull;
   logic                   up_almfull;
   logic                   up_valid;
   logic [PW-1:0]          up_payload;
   logic [1:0]             up_port;
   logic [NP-1:0]          ovf_err;

   ccip_tx_rr_arbiter #(
      .NUM_PORTS  (NP),
      .PAYLOAD_W  (PW),
      .FIFO_DEPTH (D),
      .AF_SLACK   (S),
      .QUANTUM    (Q)
   ) dut (
      .pClk       (pClk),
      .pReset_n   (pReset_n),
      .dn_valid   (dn_valid),
      .dn_payload (dn_payload),
      .dn_almfull (dn_almfull),
      .up_almfull (up_almfull),
      .up_valid   (up_valid),
      .up_payload (up_payload),
      .up_port    (up_port),
      .ovf_err    (ovf_err)
   );

   always #5 pClk = ~pClk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   // Reference model: per-port queues as shifting arrays, plus the arbitration rules.
   int            mcnt [NP];
   logic [PW-1:0] mbuf [NP][D];
   int            m_rr, m_g, m_cnt;
   bit            m_hold;
   logic          m_v;
   logic [PW-1:0] m_pay;
   logic [1:0]    m_port;
   logic [NP-1:0] m_af, m_ovf;

   task automatic model_reset();
      for (int p = 0; p < NP; p++) mcnt[p] = 0;
      m_rr = 0; m_g = 0; m_cnt = 0; m_hold = 0;
      m_v = 0; m_pay = '0; m_port = '0; m_af = '0; m_ovf = '0;
   endtask

   task automatic model_pop(input int p);
      m_v    = 1'b1;
      m_pay  = mbuf[p][0];
      m_port = 2'(p);
      for (int j = 0; j < D - 1; j++) mbuf[p][j] = mbuf[p][j+1];
      mcnt[p]--;
   endtask

   task automatic model_step();
      int start;
      bit done;
      m_v = 1'b0;
      if (!up_almfull) begin
         if (m_hold && mcnt[m_g] > 0 && m_cnt < Q) begin
            model_pop(m_g);
            m_cnt++;
         end else begin
            start  = m_hold ? (m_g + 1) % NP : m_rr;
            m_rr   = start;
            m_hold = 0;
            done   = 0;
            for (int k = 0; k < NP; k++) begin
               if (!done && mcnt[(start + k) % NP] > 0) begin
                  done   = 1;
                  m_g    = (start + k) % NP;
                  m_cnt  = 1;
                  m_hold = 1;
                  model_pop(m_g);
               end
            end
         end
      end
      for (int p = 0; p < NP; p++) begin
         if (dn_valid[p]) begin
            if (mcnt[p] < D) begin
               mbuf[p][mcnt[p]] = dn_payload[p];
               mcnt[p]++;
            end else begin
               m_ovf[p] = 1'b1;
            end
         end
         m_af[p] = (mcnt[p] >= D - S);
      end
   endtask

   task automatic cyc();
      @(posedge pClk);
      #1;
   endtask

   task automatic do_reset();
      pReset_n   = 1'b0;
      dn_valid   = '0;
      dn_payload = '0;
      up_almfull = 1'b0;
      repeat (2) @(posedge pClk);
      @(negedge pClk);
      pReset_n = 1'b1;
      model_reset();
   endtask

   typedef struct {
      logic [NP-1:0] dv;
      logic          ua;
      logic [PW-1:0] pay;
      logic          ev;
      logic [1:0]    eport;
      logic [PW-1:0] epay;
   } vec_t;

   vec_t tbl [11];

   initial begin
      tbl[0]  = '{4'b0100, 1'b0, 32'hA5, 1'b0, 2'd0, 32'h00};
      tbl[1]  = '{4'b0000, 1'b0, 32'h00, 1'b1, 2'd2, 32'hA5};
      tbl[2]  = '{4'b0000, 1'b0, 32'h00, 1'b0, 2'd2, 32'hA5};
      tbl[3]  = '{4'b1000, 1'b0, 32'h33, 1'b0, 2'd2, 32'hA5};
      tbl[4]  = '{4'b0001, 1'b0, 32'h44, 1'b1, 2'd3, 32'h33};
      tbl[5]  = '{4'b0000, 1'b0, 32'h00, 1'b1, 2'd0, 32'h44};
      tbl[6]  = '{4'b0000, 1'b0, 32'h00, 1'b0, 2'd0, 32'h44};
      tbl[7]  = '{4'b0010, 1'b1, 32'h55, 1'b0, 2'd0, 32'h44};
      tbl[8]  = '{4'b0000, 1'b1, 32'h00, 1'b0, 2'd0, 32'h44};
      tbl[9]  = '{4'b0000, 1'b0, 32'h00, 1'b1, 2'd1, 32'h55};
      tbl[10] = '{4'b0000, 1'b0, 32'h00, 1'b0, 2'd1, 32'h55};

      // Reset state
      do_reset();
      chk("rst_up_valid",   up_valid,   0);
      chk("rst_up_payload", up_payload, 0);
      chk("rst_up_port",    up_port,    0);
      chk("rst_dn_almfull", dn_almfull, 0);
      chk("rst_ovf_err",    ovf_err,    0);

      // Vector table: single beat, pointer wrap 3->0, short stall
      for (int i = 0; i < 11; i++) begin
         dn_valid   = tbl[i].dv;
         up_almfull = tbl[i].ua;
         for (int p = 0; p < NP; p++) dn_payload[p] = tbl[i].pay;
         cyc();
         chk($sformatf("tbl%0d_valid", i), up_valid,   tbl[i].ev);
         chk($sformatf("tbl%0d_port", i),  up_port,    tbl[i].eport);
         chk($sformatf("tbl%0d_pay", i),   up_payload, tbl[i].epay);
      end
      dn_valid = '0;

      // Fairness: 8 beats per port, drained in quantum-sized slices with no bubbles
      do_reset();
      up_almfull = 1'b1;
      for (int b = 0; b < 8; b++) begin
         dn_valid = '1;
         for (int p = 0; p < NP; p++) dn_payload[p] = {16'(p), 16'(b)};
         cyc();
         chk($sformatf("fair_af_b%0d", b), dn_almfull, (b + 1 >= D - S) ? 4'hF : 4'h0);
      end
      dn_valid   = '0;
      up_almfull = 1'b0;
      for (int k = 0; k < 32; k++) begin
         cyc();
         chk($sformatf("fair_valid%0d", k), up_valid, 1);
         chk($sformatf("fair_port%0d", k),  up_port, (k / 4) % 4);
         chk($sformatf("fair_pay%0d", k),   up_payload, {16'((k / 4) % 4), 16'((k / 16) * 4 + k % 4)});
      end
      cyc();
      chk("fair_drained", up_valid, 0);
      chk("fair_no_ovf",  ovf_err,  0);

      // Upstream stall mid-quantum: the same port resumes with its count preserved
      do_reset();
      up_almfull = 1'b1;
      for (int b = 0; b < 8; b++) begin
         dn_valid = 4'b0011;
         for (int p = 0; p < NP; p++) dn_payload[p] = {16'(p), 16'(b)};
         cyc();
      end
      dn_valid   = '0;
      up_almfull = 1'b0;
      for (int k = 0; k < 2; k++) begin
         cyc();
         chk($sformatf("stall_pre%0d", k), up_payload, {16'd0, 16'(k)});
      end
      up_almfull = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk($sformatf("stall_valid%0d", k), up_valid, 0);
         chk($sformatf("stall_hold%0d", k),  up_payload, 32'h0000_0001);
      end
      up_almfull = 1'b0;
      cyc(); chk("stall_res0", {up_valid, up_payload}, {1'b1, 32'h0000_0002});
      cyc(); chk("stall_res1", {up_valid, up_payload}, {1'b1, 32'h0000_0003});
      cyc(); chk("stall_res2", {up_valid, up_payload}, {1'b1, 32'h0001_0000});
      cyc(); chk("stall_res3", {up_valid, up_payload}, {1'b1, 32'h0001_0001});

      // Almost-full and sticky overflow on port 1
      do_reset();
      up_almfull = 1'b1;
      for (int n = 1; n <= 12; n++) begin
         dn_valid      = 4'b0010;
         dn_payload[1] = 32'(n);
         cyc();
         chk($sformatf("ovf_af_n%0d", n),  dn_almfull, (n >= 4) ? 4'b0010 : 4'b0000);
         chk($sformatf("ovf_err_n%0d", n), ovf_err,    (n >= 9) ? 4'b0010 : 4'b0000);
      end
      dn_valid = '0;
      repeat (2) cyc();
      chk("ovf_sticky_idle", ovf_err, 4'b0010);
      up_almfull = 1'b0;
      for (int j = 1; j <= 8; j++) begin
         cyc();
         chk($sformatf("ovf_drain%0d", j), {up_valid, up_port, up_payload}, {1'b1, 2'd1, 32'(j)});
         chk($sformatf("ovf_drain_af%0d", j), dn_almfull[1], (8 - j >= D - S));
      end
      cyc();
      chk("ovf_drained", up_valid, 0);
      chk("ovf_sticky_end", ovf_err, 4'b0010);

      // Async reset mid-burst clears outputs at once and discards queued beats
      do_reset();
      up_almfull = 1'b1;
      for (int b = 0; b < 3; b++) begin
         dn_valid = 4'b1100;
         for (int p = 0; p < NP; p++) dn_payload[p] = {16'(p), 16'(b + 1)};
         cyc();
      end
      dn_valid   = '0;
      up_almfull = 1'b0;
      cyc();
      chk("arst_pre", {up_valid, up_port}, {1'b1, 2'd2});
      @(negedge pClk);
      pReset_n = 1'b0;
      #1;
      chk("arst_valid",   up_valid,   0);
      chk("arst_payload", up_payload, 0);
      chk("arst_port",    up_port,    0);
      chk("arst_almfull", dn_almfull, 0);
      chk("arst_ovf",     ovf_err,    0);
      #3;
      pReset_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         cyc();
         chk($sformatf("arst_nostale%0d", k), {up_valid, dn_almfull}, 5'b0);
      end

      // Randomized traffic against the queue model
      do_reset();
      for (int c = 0; c < 800; c++) begin
         int rate;
         rate = (c < 400) ? 20 : 55;
         for (int p = 0; p < NP; p++) begin
            dn_valid[p]   = ($urandom_range(0, 99) < rate);
            dn_payload[p] = $urandom;
         end
         up_almfull = ($urandom_range(0, 99) < 20);
         model_step();
         cyc();
         chk($sformatf("rnd%0d_valid", c),   up_valid,   m_v);
         chk($sformatf("rnd%0d_payload", c), up_payload, m_pay);
         chk($sformatf("rnd%0d_port", c),    up_port,    m_port);
         chk($sformatf("rnd%0d_almfull", c), dn_almfull, m_af);
         chk($sformatf("rnd%0d_ovf", c),     ovf_err,    m_ovf);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
